// File: rtl/ysyx_25020047_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the IFU and LSU.
// One transaction in flight at a time; hung transactions end in an error response.
module ysyx_25020047_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                ifu_req_valid,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_req_ready,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_resp_rdata,
  output logic                ifu_resp_err,

  input  logic                lsu_req_valid,
  input  logic                lsu_req_we,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_req_ready,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_resp_rdata,
  output logic                lsu_resp_err,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  logic [1:0]        state;
  logic              last_owner;
  logic              owner;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic [CNT_W-1:0]  tmo_cnt;

  logic              grant_ifu;
  logic              grant_lsu;
  logic              accept;
  logic              busy;
  logic              resp_hit;
  logic              timed_out;
  logic              finish;
  logic              finish_err;
  logic [DATA_W-1:0] finish_rdata;

  // On conflict the requester that did not own the previous transaction wins.
  always_comb begin
    grant_lsu = lsu_req_valid && (!ifu_req_valid || (last_owner == OWNER_IFU));
    grant_ifu = ifu_req_valid && !grant_lsu;
  end

  assign ifu_req_ready = (state == S_IDLE) && grant_ifu;
  assign lsu_req_ready = (state == S_IDLE) && grant_lsu;
  assign accept        = ifu_req_ready || lsu_req_ready;

  // A real response in WAIT takes priority over a coincident timeout.
  always_comb begin
    busy         = (state == S_ISSUE) || (state == S_WAIT);
    resp_hit     = (state == S_WAIT) && mem_resp_valid;
    timed_out    = busy && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));
    finish       = resp_hit || timed_out;
    finish_err   = !resp_hit;
    finish_rdata = (resp_hit && !req_we) ? mem_resp_rdata : '0;
  end

  assign mem_req_valid = (state == S_ISSUE);
  assign mem_req_we    = req_we;
  assign mem_req_addr  = req_addr;
  assign mem_req_wdata = req_wdata;
  assign mem_req_wmask = req_wmask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      last_owner     <= OWNER_IFU;
      owner          <= OWNER_IFU;
      req_we         <= 1'b0;
      req_addr       <= '0;
      req_wdata      <= '0;
      req_wmask      <= '0;
      tmo_cnt        <= '0;
      ifu_resp_valid <= 1'b0;
      ifu_resp_rdata <= '0;
      ifu_resp_err   <= 1'b0;
      lsu_resp_valid <= 1'b0;
      lsu_resp_rdata <= '0;
      lsu_resp_err   <= 1'b0;
    end else begin
      ifu_resp_valid <= 1'b0;
      ifu_resp_err   <= 1'b0;
      lsu_resp_valid <= 1'b0;
      lsu_resp_err   <= 1'b0;

      if (finish) begin
        if (owner == OWNER_LSU) begin
          lsu_resp_valid <= 1'b1;
          lsu_resp_err   <= finish_err;
          lsu_resp_rdata <= finish_rdata;
        end else begin
          ifu_resp_valid <= 1'b1;
          ifu_resp_err   <= finish_err;
          ifu_resp_rdata <= finish_rdata;
        end
        last_owner <= owner;
        state      <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              owner     <= lsu_req_ready ? OWNER_LSU : OWNER_IFU;
              req_we    <= lsu_req_ready && lsu_req_we;
              req_addr  <= lsu_req_ready ? lsu_req_addr : ifu_req_addr;
              req_wdata <= lsu_req_ready ? lsu_req_wdata : '0;
              req_wmask <= (lsu_req_ready && lsu_req_we) ? lsu_req_wmask : '0;
              tmo_cnt   <= '0;
              state     <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
            if (mem_req_ready) state <= S_WAIT;
          end
          S_WAIT: begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter; the bench plays both requesters
// and the downstream memory, stepping one cycle at a time.
module tb_ysyx_25020047_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TMO    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;

  logic              ifu_req_valid = 1'b0;
  logic [ADDR_W-1:0] ifu_req_addr  = '0;
  logic              ifu_req_ready;
  logic              ifu_resp_valid;
  logic [DATA_W-1:0] ifu_resp_rdata;
  logic              ifu_resp_err;

  logic              lsu_req_valid = 1'b0;
  logic              lsu_req_we    = 1'b0;
  logic [ADDR_W-1:0] lsu_req_addr  = '0;
  logic [DATA_W-1:0] lsu_req_wdata = '0;
  logic [3:0]        lsu_req_wmask = '0;
  logic              lsu_req_ready;
  logic              lsu_resp_valid;
  logic [DATA_W-1:0] lsu_resp_rdata;
  logic              lsu_resp_err;

  logic              mem_req_valid;
  logic              mem_req_ready  = 1'b0;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [3:0]        mem_req_wmask;
  logic              mem_resp_valid = 1'b0;
  logic [DATA_W-1:0] mem_resp_rdata = '0;

  int tests_run    = 0;
  int tests_failed = 0;

  ysyx_25020047_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_rdata(ifu_resp_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_we(lsu_req_we), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask), .lsu_req_ready(lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Helpers: all driving and sampling happens 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory accepts the ISSUE immediately and answers one cycle later.
  task automatic mem_serve(input logic [DATA_W-1:0] rdata);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rdata;
    step();
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_ifu_resp_valid", 64'(ifu_resp_valid), 64'd0);
    check("rst_lsu_resp_valid", 64'(lsu_resp_valid), 64'd0);
    check("rst_ifu_rdata", 64'(ifu_resp_rdata), 64'd0);
    check("rst_mem_req_addr", 64'(mem_req_addr), 64'd0);
    rst = 1'b0;
    step();

    // Single IFU read
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0000;
    #1;
    check("ifu_rd_ready", 64'(ifu_req_ready), 64'd1);
    check("ifu_rd_lsu_ready", 64'(lsu_req_ready), 64'd0);
    step();
    ifu_req_valid = 1'b0;
    check("ifu_rd_mem_valid", 64'(mem_req_valid), 64'd1);
    check("ifu_rd_mem_addr", 64'(mem_req_addr), 64'h8000_0000);
    check("ifu_rd_mem_we", 64'(mem_req_we), 64'd0);
    check("ifu_rd_mem_wmask", 64'(mem_req_wmask), 64'd0);
    check("ifu_rd_no_ready_busy", 64'(ifu_req_ready), 64'd0);
    mem_serve(32'h0000_0413);
    check("ifu_rd_resp_valid", 64'(ifu_resp_valid), 64'd1);
    check("ifu_rd_rdata", 64'(ifu_resp_rdata), 64'h0000_0413);
    check("ifu_rd_err", 64'(ifu_resp_err), 64'd0);
    check("ifu_rd_lsu_quiet", 64'(lsu_resp_valid), 64'd0);
    step();
    check("ifu_rd_pulse_once", 64'(ifu_resp_valid), 64'd0);

    // LSU store, with a stray response during ISSUE that must be ignored
    lsu_req_valid = 1'b1;
    lsu_req_we    = 1'b1;
    lsu_req_addr  = 32'h8000_1002;
    lsu_req_wdata = 32'h00AB_0000;
    lsu_req_wmask = 4'b0100;
    #1;
    check("st_ready", 64'(lsu_req_ready), 64'd1);
    step();
    lsu_req_valid = 1'b0;
    check("st_mem_we", 64'(mem_req_we), 64'd1);
    check("st_mem_addr", 64'(mem_req_addr), 64'h8000_1002);
    check("st_mem_wdata", 64'(mem_req_wdata), 64'h00AB_0000);
    check("st_mem_wmask", 64'(mem_req_wmask), 64'h4);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hDEAD_BEEF;
    step();
    mem_resp_valid = 1'b0;
    check("st_issue_ignore_resp", 64'(lsu_resp_valid), 64'd0);
    check("st_issue_hold_valid", 64'(mem_req_valid), 64'd1);
    mem_serve(32'hDEAD_BEEF);
    check("st_resp_valid", 64'(lsu_resp_valid), 64'd1);
    check("st_resp_rdata_zero", 64'(lsu_resp_rdata), 64'd0);
    check("st_resp_err", 64'(lsu_resp_err), 64'd0);
    check("st_ifu_quiet", 64'(ifu_resp_valid), 64'd0);
    step();
    check("st_pulse_once", 64'(lsu_resp_valid), 64'd0);

    // Conflict after reset: strict alternation starting with the LSU
    rst = 1'b1;
    step();
    rst = 1'b0;
    lsu_req_we    = 1'b0;
    lsu_req_wmask = 4'hF;
    lsu_req_addr  = 32'h8000_2000;
    ifu_req_addr  = 32'h8000_0040;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      logic exp_lsu;
      exp_lsu = (i % 2 == 0);
      check($sformatf("cf%0d_lsu_ready", i), 64'(lsu_req_ready), 64'(exp_lsu));
      check($sformatf("cf%0d_ifu_ready", i), 64'(ifu_req_ready), 64'(!exp_lsu));
      step();
      check($sformatf("cf%0d_mem_addr", i), 64'(mem_req_addr),
            exp_lsu ? 64'h8000_2000 : 64'h8000_0040);
      check($sformatf("cf%0d_mem_wmask", i), 64'(mem_req_wmask), 64'd0);
      mem_serve(32'h1000 + 32'(i));
      check($sformatf("cf%0d_lsu_resp", i), 64'(lsu_resp_valid), 64'(exp_lsu));
      check($sformatf("cf%0d_ifu_resp", i), 64'(ifu_resp_valid), 64'(!exp_lsu));
      check($sformatf("cf%0d_rdata", i),
            64'(exp_lsu ? lsu_resp_rdata : ifu_resp_rdata), 64'h1000 + 64'(i));
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    step();

    // Timeout: LSU load never accepted downstream
    lsu_req_valid = 1'b1;
    lsu_req_addr  = 32'h8000_3000;
    #1;
    check("tmo_ready", 64'(lsu_req_ready), 64'd1);
    step();
    lsu_req_valid = 1'b0;
    for (int k = 1; k <= TMO + 1; k++) begin
      check($sformatf("tmo_wait%0d_resp", k), 64'(lsu_resp_valid), 64'd0);
      check($sformatf("tmo_wait%0d_mem_valid", k), 64'(mem_req_valid), 64'd1);
      step();
    end
    check("tmo_resp_valid", 64'(lsu_resp_valid), 64'd1);
    check("tmo_resp_err", 64'(lsu_resp_err), 64'd1);
    check("tmo_resp_rdata", 64'(lsu_resp_rdata), 64'd0);
    check("tmo_mem_valid_drop", 64'(mem_req_valid), 64'd0);
    check("tmo_ifu_quiet", 64'(ifu_resp_valid), 64'd0);
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0080;
    #1;
    check("tmo_next_ready", 64'(ifu_req_ready), 64'd1);
    step();
    ifu_req_valid = 1'b0;
    mem_serve(32'h0000_0013);
    check("tmo_next_resp", 64'(ifu_resp_valid), 64'd1);
    check("tmo_next_err", 64'(ifu_resp_err), 64'd0);
    check("tmo_next_rdata", 64'(ifu_resp_rdata), 64'h0000_0013);
    step();

    // Reset asserted in WAIT; late response must be dropped
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_00C0;
    step();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rwait_async_mem_valid", 64'(mem_req_valid), 64'd0);
    check("rwait_async_addr", 64'(mem_req_addr), 64'd0);
    step();
    rst = 1'b0;
    step();
    step();
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h5555_AAAA;
    step();
    mem_resp_valid = 1'b0;
    check("rwait_ifu_quiet", 64'(ifu_resp_valid), 64'd0);
    check("rwait_lsu_quiet", 64'(lsu_resp_valid), 64'd0);
    step();
    check("rwait_ifu_quiet2", 64'(ifu_resp_valid), 64'd0);
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0100;
    #1;
    check("rwait_idle_ready", 64'(ifu_req_ready), 64'd1);
    step();
    ifu_req_valid = 1'b0;
    check("rwait_mem_addr", 64'(mem_req_addr), 64'h8000_0100);
    mem_serve(32'h0000_0297);
    check("rwait_resp", 64'(ifu_resp_valid), 64'd1);
    check("rwait_rdata", 64'(ifu_resp_rdata), 64'h0000_0297);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
